// File: rtl/md5_block_padder.sv
// MD5 block padder: packs a byte stream into 512-bit blocks and appends the
// MD5 padding (0x80, zero fill, 64-bit little-endian bit length).
module md5_block_padder #(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, PAD, LENBLK, EMIT} state_t;

    state_t             state_q, state_d;
    logic [5:0]         pos_q, pos_d;
    logic [5:0]         c_q, c_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               pad_pending_q, pad_pending_d;
    logic               len_pending_q, len_pending_d;
    logic               first_flag_q, first_flag_d;
    logic               in_ready_q, in_ready_d;
    logic               blk_valid_q, blk_valid_d;
    logic               blk_first_q, blk_first_d;
    logic               blk_last_q, blk_last_d;
    logic [511:0]       blk_data_q, blk_data_d;
    logic [63:0]        bit_len;

    // Message length in bits, taken from the running byte count.
    assign bit_len = 64'({cnt_q, 3'b000});

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_data_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

    // Next-state logic: byte packing, padding, length block and emit handshake.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        c_d           = c_q;
        cnt_d         = cnt_q;
        pad_pending_d = pad_pending_q;
        len_pending_d = len_pending_q;
        first_flag_d  = first_flag_q;
        blk_data_d    = blk_data_q;
        blk_first_d   = blk_first_q;
        blk_last_d    = blk_last_q;

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    blk_data_d[{pos_q, 3'b000} +: 8] = in_data;
                    pos_d = pos_q + 6'd1;
                    cnt_d = cnt_q + 1'b1;
                    if (pos_q == 6'd63) begin
                        // Block full: emit it as non-final; a last byte here
                        // means the padding goes into a fresh block.
                        state_d       = EMIT;
                        blk_first_d   = first_flag_q;
                        blk_last_d    = 1'b0;
                        pad_pending_d = in_last;
                    end else if (in_last) begin
                        state_d = PAD;
                        c_d     = pos_q + 6'd1;
                    end
                end
            end
            PAD: begin
                for (int k = 0; k < 64; k++) begin
                    if (k == int'(c_q)) begin
                        blk_data_d[8*k +: 8] = 8'h80;
                    end else if (k > int'(c_q)) begin
                        blk_data_d[8*k +: 8] = 8'h00;
                    end
                    if ((c_q <= 6'd55) && (k >= 56)) begin
                        blk_data_d[8*k +: 8] = bit_len[8*(k-56) +: 8];
                    end
                end
                // No room left for the length: it goes into a trailing block.
                len_pending_d = (c_q > 6'd55);
                blk_last_d    = (c_q <= 6'd55);
                blk_first_d   = first_flag_q;
                state_d       = EMIT;
            end
            LENBLK: begin
                blk_data_d           = '0;
                blk_data_d[511:448]  = bit_len;
                blk_first_d          = first_flag_q;
                blk_last_d           = 1'b1;
                state_d              = EMIT;
            end
            EMIT: begin
                if (blk_ready) begin
                    first_flag_d = 1'b0;
                    blk_first_d  = 1'b0;
                    blk_last_d   = 1'b0;
                    if (pad_pending_q) begin
                        state_d       = PAD;
                        c_d           = 6'd0;
                        pad_pending_d = 1'b0;
                    end else if (len_pending_q) begin
                        state_d       = LENBLK;
                        len_pending_d = 1'b0;
                    end else begin
                        state_d = FILL;
                        pos_d   = 6'd0;
                    end
                    if (blk_last_q) begin
                        cnt_d        = '0;
                        first_flag_d = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake outputs are registered from the upcoming state.
    always_comb begin
        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d == EMIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            pos_q         <= '0;
            c_q           <= '0;
            cnt_q         <= '0;
            pad_pending_q <= 1'b0;
            len_pending_q <= 1'b0;
            first_flag_q  <= 1'b1;
            in_ready_q    <= 1'b0;
            blk_valid_q   <= 1'b0;
            blk_first_q   <= 1'b0;
            blk_last_q    <= 1'b0;
            blk_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            c_q           <= c_d;
            cnt_q         <= cnt_d;
            pad_pending_q <= pad_pending_d;
            len_pending_q <= len_pending_d;
            first_flag_q  <= first_flag_d;
            in_ready_q    <= in_ready_d;
            blk_valid_q   <= blk_valid_d;
            blk_first_q   <= blk_first_d;
            blk_last_q    <= blk_last_d;
            blk_data_q    <= blk_data_d;
        end
    end

endmodule

// File: doc/md5_block_padder.md
MD5_BLOCK_PADDER -- requirements
Module: md5_block_padder

Interface
REQ-001 Parameter: LEN_W, 61, width of the internal message byte counter; bit length = {count, 3'b000} zero-extended to 64 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-005 in_ready  output  1  block accepts a byte; transfer occurs when in_valid && in_ready.
REQ-006 in_data  input  8  message byte.
REQ-007 in_last  input  1  accompanying byte is the final byte of the message.
REQ-008 blk_valid  output  1  blk_data holds a complete 512-bit block.
REQ-009 blk_ready  input  1  downstream consumes the block; transfer occurs when blk_valid && blk_ready.
REQ-010 blk_data  output  512  block for the MD5 pipeline wb input; byte k occupies blk_data[8k+7:8k].
REQ-011 blk_first  output  1  block is the first of its message (downstream loads initial chaining values).
REQ-012 blk_last  output  1  block is the final padded block of its message.

Function
REQ-013 States: FILL, PAD, LENBLK, EMIT.
REQ-014 FILL: in_ready = 1; each accepted byte is written to byte position pos (0..63), pos increments, byte counter increments.
REQ-015 FILL, accepted byte with in_last = 0 and pos = 63: next state EMIT, block non-final; blk_valid asserted the following cycle.
REQ-016 FILL, accepted byte with in_last = 1 and pos < 63: next state PAD with c = pos + 1.
REQ-017 FILL, accepted byte with in_last = 1 and pos = 63: next state EMIT, block non-final, pad_pending set.
REQ-018 PAD (one cycle, in_ready = 0): write 0x80 at byte c and 0x00 at bytes c+1..63; if c <= 55, write the 64-bit bit length little-endian into bytes 56..63 and mark the block final; else set len_pending and mark it non-final; next state EMIT.
REQ-019 pad_pending entry to PAD uses c = 0 (block = 0x80, zeros, length).
REQ-020 LENBLK (one cycle): bytes 0..55 = 0x00, bytes 56..63 = bit length, block final; next state EMIT.
REQ-021 EMIT: blk_valid = 1, in_ready = 0; blk_data, blk_first and blk_last are held stable until the handshake.
REQ-022 On EMIT handshake: if pad_pending, go to PAD; else if len_pending, go to LENBLK; else go to FILL with pos = 0; after a final block, also clear the byte counter and set first_flag.
REQ-023 blk_first = 1 on the first emitted block of each message only; blk_last = 1 on the final block only; both are 0 when blk_valid = 0.
REQ-024 Latency: full non-last block: blk_valid in the cycle after the 64th byte is accepted; last byte: blk_valid 2 cycles after acceptance.
REQ-025 Bit length = total accepted bytes x 8 (mod 2^64); the byte counter wraps silently at 2^LEN_W.
REQ-026 Zero-length messages are not supported; every message carries at least one byte.
REQ-027 Bytes beyond those written in the current block are don't-care internally but are always overwritten before emission.

Reset
REQ-028 While reset is high at a clock edge: state = FILL, pos = 0, byte counter = 0, pad_pending = len_pending = 0, first_flag = 1, blk_valid = 0, blk_first = 0, blk_last = 0, in_ready = 0, blk_data = 0.
REQ-029 in_ready rises the first cycle after reset deasserts.
REQ-030 Reset mid-message or mid-EMIT discards the partial message and any pending block; no block is emitted for it.

Verification
REQ-031 "abc" (61 62 63, last on 63) -> one block: bytes 0..3 = 61 62 63 80, byte 56 = 0x18, all other bytes 0; blk_first = blk_last = 1.
REQ-032 55 x 0x41 -> one block: byte 55 = 0x80, bytes 56..57 = B8 01; first = last = 1.
REQ-033 56 x 0x41 -> block 1: byte 56 = 0x80, first = 1, last = 0; block 2: zeros, bytes 56..57 = C0 01, first = 0, last = 1.
REQ-034 64 x 0x41 -> block 1: all 0x41, non-final; block 2: byte 0 = 0x80, bytes 56..57 = 00 02, last = 1.
REQ-035 "abc" with blk_ready held low 5 cycles -> blk_valid stays high, blk_data unchanged, in_ready = 0; handshake on cycle 6, then in_ready = 1.
REQ-036 Reset asserted after 30 bytes, then "abc" -> exactly one block, identical to REQ-031, blk_first = 1.
